// File: rtl/desp_sprite_fetch.sv
// desp_sprite_fetch
//   Upstream pixel-fetch stage for the desp character sprite. Converts the
//   current VGA draw coordinate into a sprite ROM address (with optional
//   horizontal mirroring), then carries the ROM's colour index and the pose
//   that produced it to the per-pose palette mux. Character state (pose,
//   facing, position) is latched only on frame_start, so a frame never tears.
//
// Ports
//   Clk          pixel clock
//   Reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse at start of vertical blank (shadow latch)
//   revive       one-cycle pulse that leaves the sticky DEAD state
//   pix_active   drawX/drawY are in the visible area
//   drawX/drawY  current pixel column/row
//   posX/posY    requested sprite top-left corner
//   pose_req     requested pose code (0..NUM_POSES-1)
//   face_left    request horizontal mirroring
//   rom_addr     sprite ROM address (registered)
//   rom_pose     ROM bank select, aligned with rom_addr
//   rom_data     colour index returned one cycle after rom_addr
//   pal_index    colour index to palette (0 when pal_valid is low)
//   pal_pose     palette select, aligned with pal_index
//   pal_valid    pixel lies inside the sprite box
//   Latency drawX/drawY -> pal_*: 3 cycles, one pixel per cycle, no stall.

module desp_sprite_fetch #(
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 96,
    parameter int ADDR_W    = 13,
    parameter int NUM_POSES = 9
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              revive,
    input  logic              pix_active,
    input  logic [9:0]        drawX,
    input  logic [9:0]        drawY,
    input  logic [9:0]        posX,
    input  logic [9:0]        posY,
    input  logic [3:0]        pose_req,
    input  logic              face_left,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        rom_pose,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    output logic [3:0]        pal_pose,
    output logic              pal_valid
);

    localparam int          COL_W       = $clog2(SPR_W);
    localparam logic [3:0]  POSE_DEAD   = 4'd3;
    localparam logic [3:0]  POSE_STAND  = 4'd8;
    localparam logic [3:0]  POSE_LIMIT  = 4'(NUM_POSES);
    localparam logic [10:0] SPR_W_11    = 11'(SPR_W);
    localparam logic [10:0] SPR_H_11    = 11'(SPR_H);

    typedef enum logic {
        ALIVE = 1'b0,
        DEAD  = 1'b1
    } state_e;

    // ---------------- shadow character state ----------------
    state_e      state_q;
    logic [3:0]  pose_q;
    logic        face_q;
    logic [9:0]  posx_q;
    logic [9:0]  posy_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ALIVE;
            pose_q  <= POSE_STAND;
            face_q  <= 1'b0;
            posx_q  <= '0;
            posy_q  <= '0;
        end else begin
            // revive outside a frame boundary only leaves DEAD; the pose
            // itself stays 3 until the next frame_start latches a new one.
            if (revive && (state_q == DEAD) && !frame_start) begin
                state_q <= ALIVE;
            end
            if (frame_start) begin
                face_q <= face_left;
                posx_q <= posX;
                posy_q <= posY;
                // revive in the same cycle is applied first, so the request
                // is then judged under ALIVE rules.
                if ((state_q == DEAD) && !revive) begin
                    pose_q <= POSE_DEAD;
                end else if (pose_req < POSE_LIMIT) begin
                    pose_q  <= pose_req;
                    state_q <= (pose_req == POSE_DEAD) ? DEAD : ALIVE;
                end else begin
                    // out-of-range request: keep the previous pose
                    state_q <= ALIVE;
                end
            end
        end
    end

    // ---------------- hit test and address generation ----------------
    // All box compares are done in 11 bits so posX+SPR_W never wraps.
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              hit_d;
    logic [COL_W-1:0]  dx;
    logic [10:0]       dy;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] rom_addr_d;

    always_comb begin
        x_end = {1'b0, posx_q} + SPR_W_11;
        y_end = {1'b0, posy_q} + SPR_H_11;
        hit_d = pix_active
             && ({1'b0, drawX} >= {1'b0, posx_q}) && ({1'b0, drawX} < x_end)
             && ({1'b0, drawY} >= {1'b0, posy_q}) && ({1'b0, drawY} < y_end);
        // Only the low COL_W bits of dx matter inside the box.
        dx    = drawX[COL_W-1:0] - posx_q[COL_W-1:0];
        dy    = {1'b0, drawY} - {1'b0, posy_q};
        // SPR_W is a power of two, so SPR_W-1-dx is just the bitwise inverse.
        col   = face_q ? ~dx : dx;
        rom_addr_d = hit_d ? (ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col)) : '0;
    end

    // ---------------- pipeline ----------------
    logic [ADDR_W-1:0] rom_addr_q;
    logic [3:0]        rom_pose_q;
    logic              hit1_q;
    logic              hit2_q;
    logic [3:0]        pose2_q;
    logic [3:0]        pal_index_q;
    logic [3:0]        pal_pose_q;
    logic              pal_valid_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            rom_pose_q  <= POSE_STAND;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            pose2_q     <= POSE_STAND;
            pal_index_q <= '0;
            pal_pose_q  <= POSE_STAND;
            pal_valid_q <= 1'b0;
        end else begin
            // stage 1: address out to the ROM, pose captured with the pixel
            rom_addr_q  <= rom_addr_d;
            rom_pose_q  <= pose_q;
            hit1_q      <= hit_d;
            // stage 2: ROM registers its data; carry hit and pose alongside
            hit2_q      <= hit1_q;
            pose2_q     <= rom_pose_q;
            // stage 3: palette outputs, index forced to 0 outside the box
            pal_index_q <= hit2_q ? rom_data : 4'd0;
            pal_pose_q  <= pose2_q;
            pal_valid_q <= hit2_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_pose  = rom_pose_q;
    assign pal_index = pal_index_q;
    assign pal_pose  = pal_pose_q;
    assign pal_valid = pal_valid_q;

endmodule

// File: doc/desp_sprite_fetch.md
Name: desp_sprite_fetch

Overview:
Upstream pixel-fetch stage for the desp character sprite. It takes the current VGA draw coordinate and the character's pose, position and facing, and computes the sprite ROM address with horizontal mirroring. It pipelines the returned 4-bit colour index, together with the matching pose select, to the desp per-pose palette mux. Character state is latched once per frame, so a pose change can never tear mid-frame.

Parameters:
SPR_W, 64, sprite width in pixels; must be a power of two.
SPR_H, 96, sprite height in pixels.
ADDR_W, 13, ROM address width; must be at least log2(SPR_W*SPR_H).
NUM_POSES, 9, number of valid pose codes. Codes: 0 block, 1 crouch, 2 crouchpunch, 3 dead, 4 jump, 5 kick, 6 move, 7 punch, 8 stand.

Ports:
Clk  in  1  pixel clock.
Reset_n  in  1  reset, active-low.
frame_start  in  1  one-cycle pulse at the start of vertical blank.
revive  in  1  one-cycle pulse that clears the sticky dead state.
pix_active  in  1  high while drawX/drawY are in the visible area.
drawX  in  10  current pixel column.
drawY  in  10  current pixel row.
posX  in  10  sprite top-left column (request).
posY  in  10  sprite top-left row (request).
pose_req  in  4  requested pose code.
face_left  in  1  request to mirror the sprite horizontally.
rom_addr  out  ADDR_W  address to the synchronous sprite ROM.
rom_pose  out  4  pose select to the ROM bank mux.
rom_data  in  4  colour index; valid one cycle after rom_addr is registered.
pal_index  out  4  colour index to the palette.
pal_pose  out  4  palette select, aligned with pal_index.
pal_valid  out  1  pixel lies inside the sprite box, aligned with pal_index.

Behaviour:
- Reset (Reset_n low) is asynchronous and active-low. On assertion:
  - rom_addr, pal_index, pal_valid and all pipeline valid bits clear to 0.
  - Shadow pose = 8 (stand), rom_pose = pal_pose = 8.
  - Shadow face = 0, shadow posX/posY = 0, FSM = ALIVE.
- Reset mid-frame: outputs clear immediately; the pipeline refills only after Reset_n deasserts.
- Shadow registers (pose, face, posX, posY) update only on cycles where frame_start = 1. At all other times, input changes are ignored.
- Pose FSM, evaluated on frame_start:
  - ALIVE: if pose_req >= NUM_POSES, hold the previous shadow pose. Otherwise latch pose_req. If the latched code is 3, go to DEAD.
  - DEAD: shadow pose is forced to 3. pose_req is ignored; posX, posY and face still latch.
  - A revive pulse in DEAD moves the FSM to ALIVE immediately. If revive and frame_start occur in the same cycle, revive takes effect first and pose_req is then latched under ALIVE rules. revive in ALIVE has no effect.
- Hit test, combinational on cycle-N inputs. All compares are 11-bit unsigned, with no wrap; posX+SPR_W may exceed 1023.
  - hit = pix_active && drawX >= posX && drawX < posX+SPR_W && drawY >= posY && drawY < posY+SPR_H.
  - dx = drawX-posX, dy = drawY-posY.
  - col = face ? SPR_W-1-dx : dx.
- Pipeline:
  - Edge N+1: rom_addr <= hit ? {dy, col} (i.e. dy*SPR_W+col, truncated to ADDR_W) : 0. rom_pose <= shadow pose. hit1 <= hit.
  - Edge N+2: the ROM registers rom_data. hit2 <= hit1, pose2 <= rom_pose.
  - Edge N+3: pal_index <= hit2 ? rom_data : 0. pal_pose <= pose2. pal_valid <= hit2.
- Total latency from drawX/drawY to pal_*: 3 cycles, fixed. One pixel is accepted per cycle; there is no stall.
- pal_valid = 0 forces pal_index = 0. Transparency (key colour F0F) is decided downstream from palette RGB, not here.
- A shadow update on frame_start affects only pixels sampled on later cycles. In-flight pixels keep their captured pose.

Test Plan:
1. Reset_n low mid-stream -> all outputs 0 and rom_pose = 8 within the same cycle. After release with pix_active = 0 -> pal_valid stays 0.
2. posX = 100, posY = 50, face = 0, pose_req = 8, then frame_start. drawX = 100, drawY = 50 -> rom_addr = 0 at N+1. Drive rom_data = 4'hA at N+2 -> pal_index = A, pal_valid = 1, pal_pose = 8 at N+3. drawX = 163, drawY = 50 -> rom_addr = 63. drawX = 164 -> pal_valid = 0.
3. face_left = 1, same position: drawX = 100, drawY = 51 -> rom_addr = 64+63 = 127. drawX = 163 -> rom_addr = 64.
4. pose_req = 7 changed mid-frame -> pal_pose stays 8 until the next frame_start, then becomes 7. pose_req = 12 -> pose holds at 7.
5. pose_req = 3 then frame_start -> DEAD. Next frame pose_req = 7 -> pal_pose stays 3. revive and frame_start in the same cycle with pose_req = 8 -> pal_pose = 8.
6. posX = 1000, drawX = 1023 -> hit, rom_addr col = 23, no wrap. drawY = posY+SPR_H -> pal_valid = 0.
